// File: rtl/dma_lite_pkg.sv
// Shared definitions for the DMA-lite status responder.
// Holds register offsets, DMACR/DMASR bit positions, AXI-lite response codes,
// read/write FSM state encodings and the register address decoder used by
// both the read and write paths.
package dma_lite_pkg;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 32;

  localparam logic [ADDR_W-1:0] MM2S_DMACR_OFS = 10'h000;
  localparam logic [ADDR_W-1:0] MM2S_DMASR_OFS = 10'h004;
  localparam logic [ADDR_W-1:0] S2MM_DMACR_OFS = 10'h030;
  localparam logic [ADDR_W-1:0] S2MM_DMASR_OFS = 10'h034;

  // DMACR bits
  localparam int unsigned DMACR_RS_BIT        = 0;
  localparam int unsigned DMACR_IOC_IRQEN_BIT = 12;
  // DMASR bits
  localparam int unsigned DMASR_HALTED_BIT    = 0;
  localparam int unsigned DMASR_IDLE_BIT      = 1;
  localparam int unsigned DMASR_IOC_IRQ_BIT   = 12;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_ADDR_OK,
    W_DATA_OK,
    W_RESP
  } wr_state_e;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_MM2S_CR,
    SEL_MM2S_SR,
    SEL_S2MM_CR,
    SEL_S2MM_SR
  } reg_sel_e;

  // Exact 10-bit match; misaligned addresses fall through to SEL_NONE.
  function automatic reg_sel_e decode_addr(input logic [ADDR_W-1:0] addr);
    reg_sel_e sel;
    case (addr)
      MM2S_DMACR_OFS: sel = SEL_MM2S_CR;
      MM2S_DMASR_OFS: sel = SEL_MM2S_SR;
      S2MM_DMACR_OFS: sel = SEL_S2MM_CR;
      S2MM_DMASR_OFS: sel = SEL_S2MM_SR;
      default:        sel = SEL_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/dma_lite_chan_regs.sv
// Per-channel DMACR/DMASR register set.
// Ports:
//   clk, rst      - clock, synchronous active-low reset
//   busy          - engine busy input for this channel
//   cr_we, sr_we  - single-cycle write strobes for DMACR / DMASR
//   wbit_rs       - write data bit 0 (RS) for DMACR
//   wbit_12       - write data bit 12 (IOC_IrqEn for DMACR, W1C IOC_Irq for DMASR)
//   run           - RS, drives the engine run output
//   cr, sr        - current DMACR / DMASR read values
//   irq_req       - IOC_Irq & IOC_IrqEn, before the top-level irq register
module dma_lite_chan_regs
  import dma_lite_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              busy,
  input  logic              cr_we,
  input  logic              sr_we,
  input  logic              wbit_rs,
  input  logic              wbit_12,
  output logic              run,
  output logic [DATA_W-1:0] cr,
  output logic [DATA_W-1:0] sr,
  output logic              irq_req
);

  logic rs;
  logic ioc_en;
  logic ioc;
  logic busy_q;
  logic ioc_set;
  logic ioc_clr;

  assign ioc_set = busy_q & ~busy & rs;
  assign ioc_clr = sr_we & wbit_12;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rs     <= 1'b0;
      ioc_en <= 1'b0;
      ioc    <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      busy_q <= busy;
      if (cr_we) begin
        rs     <= wbit_rs;
        ioc_en <= wbit_12;
      end
      // A completion in the same cycle as a W1C keeps the flag set.
      ioc <= ioc_set | (ioc & ~ioc_clr);
    end
  end

  always_comb begin
    cr = '0;
    cr[DMACR_RS_BIT]        = rs;
    cr[DMACR_IOC_IRQEN_BIT] = ioc_en;
    sr = '0;
    sr[DMASR_HALTED_BIT]    = ~rs;
    sr[DMASR_IDLE_BIT]      = rs & ~busy;
    sr[DMASR_IOC_IRQ_BIT]   = ioc;
  end

  assign run     = rs;
  assign irq_req = ioc & ioc_en;

endmodule

// File: rtl/dma_lite_status_responder.sv
// AXI4-lite slave exposing MM2S/S2MM DMACR and DMASR registers.
// Ports:
//   clk, rst                 - clock, synchronous active-low reset
//   s_axi_lite_ar*/r*        - read address / read data channels
//   s_axi_lite_aw*/w*/b*     - write address / write data / write response
//   mm2s_busy, s2mm_busy     - engine busy inputs
//   mm2s_run, s2mm_run       - DMACR.RS of each channel
//   irq                      - registered OR of enabled IOC interrupts
module dma_lite_status_responder
  import dma_lite_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] s_axi_lite_araddr,
  input  logic              s_axi_lite_arvalid,
  output logic              s_axi_lite_arready,
  output logic [DATA_W-1:0] s_axi_lite_rdata,
  output logic [1:0]        s_axi_lite_rresp,
  output logic              s_axi_lite_rvalid,
  input  logic              s_axi_lite_rready,
  input  logic [ADDR_W-1:0] s_axi_lite_awaddr,
  input  logic              s_axi_lite_awvalid,
  output logic              s_axi_lite_awready,
  input  logic [DATA_W-1:0] s_axi_lite_wdata,
  input  logic              s_axi_lite_wvalid,
  output logic              s_axi_lite_wready,
  output logic [1:0]        s_axi_lite_bresp,
  output logic              s_axi_lite_bvalid,
  input  logic              s_axi_lite_bready,
  input  logic              mm2s_busy,
  input  logic              s2mm_busy,
  output logic              mm2s_run,
  output logic              s2mm_run,
  output logic              irq
);

  // Ready outputs stay low during reset and rise one cycle after release.
  logic ready_en;

  always_ff @(posedge clk) begin
    if (!rst) ready_en <= 1'b0;
    else      ready_en <= 1'b1;
  end

  // Channel registers
  logic [DATA_W-1:0] mm2s_cr, mm2s_sr, s2mm_cr, s2mm_sr;
  logic              mm2s_irq_req, s2mm_irq_req;
  logic              mm2s_cr_we, mm2s_sr_we, s2mm_cr_we, s2mm_sr_we;
  logic              wbit_rs, wbit_12;

  dma_lite_chan_regs u_mm2s (
    .clk     (clk),
    .rst     (rst),
    .busy    (mm2s_busy),
    .cr_we   (mm2s_cr_we),
    .sr_we   (mm2s_sr_we),
    .wbit_rs (wbit_rs),
    .wbit_12 (wbit_12),
    .run     (mm2s_run),
    .cr      (mm2s_cr),
    .sr      (mm2s_sr),
    .irq_req (mm2s_irq_req)
  );

  dma_lite_chan_regs u_s2mm (
    .clk     (clk),
    .rst     (rst),
    .busy    (s2mm_busy),
    .cr_we   (s2mm_cr_we),
    .sr_we   (s2mm_sr_we),
    .wbit_rs (wbit_rs),
    .wbit_12 (wbit_12),
    .run     (s2mm_run),
    .cr      (s2mm_cr),
    .sr      (s2mm_sr),
    .irq_req (s2mm_irq_req)
  );

  always_ff @(posedge clk) begin
    if (!rst) irq <= 1'b0;
    else      irq <= mm2s_irq_req | s2mm_irq_req;
  end

  // Read path
  rd_state_e         rstate, rstate_next;
  logic              ar_hs;
  logic [DATA_W-1:0] rd_word;
  logic [1:0]        rd_resp;

  always_comb begin
    rd_word = '0;
    rd_resp = RESP_OKAY;
    case (decode_addr(s_axi_lite_araddr))
      SEL_MM2S_CR: rd_word = mm2s_cr;
      SEL_MM2S_SR: rd_word = mm2s_sr;
      SEL_S2MM_CR: rd_word = s2mm_cr;
      SEL_S2MM_SR: rd_word = s2mm_sr;
      default:     rd_resp = RESP_SLVERR;
    endcase
  end

  always_comb begin
    rstate_next        = rstate;
    s_axi_lite_arready = 1'b0;
    s_axi_lite_rvalid  = 1'b0;
    ar_hs              = 1'b0;
    case (rstate)
      R_IDLE: begin
        s_axi_lite_arready = ready_en;
        if (s_axi_lite_arvalid && ready_en) begin
          ar_hs       = 1'b1;
          rstate_next = R_DATA;
        end
      end
      R_DATA: begin
        s_axi_lite_rvalid = 1'b1;
        if (s_axi_lite_rready) rstate_next = R_IDLE;
      end
      default: rstate_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rstate           <= R_IDLE;
      s_axi_lite_rdata <= '0;
      s_axi_lite_rresp <= RESP_OKAY;
    end else begin
      rstate <= rstate_next;
      if (ar_hs) begin
        s_axi_lite_rdata <= rd_word;
        s_axi_lite_rresp <= rd_resp;
      end
    end
  end

  // Write path
  wr_state_e         wstate, wstate_next;
  logic              aw_hs, w_hs, commit;
  logic [ADDR_W-1:0] awaddr_q, wr_addr;
  logic              wrs_q, w12_q;
  reg_sel_e          wr_sel;
  logic              wdata_unused;

  assign wdata_unused = ^{s_axi_lite_wdata[DATA_W-1:13], s_axi_lite_wdata[11:1]};

  always_comb begin
    wstate_next        = wstate;
    s_axi_lite_awready = 1'b0;
    s_axi_lite_wready  = 1'b0;
    s_axi_lite_bvalid  = 1'b0;
    aw_hs              = 1'b0;
    w_hs               = 1'b0;
    commit             = 1'b0;
    case (wstate)
      W_IDLE: begin
        s_axi_lite_awready = ready_en;
        s_axi_lite_wready  = ready_en;
        aw_hs = s_axi_lite_awvalid & ready_en;
        w_hs  = s_axi_lite_wvalid & ready_en;
        if (aw_hs && w_hs) begin
          commit      = 1'b1;
          wstate_next = W_RESP;
        end else if (aw_hs) begin
          wstate_next = W_ADDR_OK;
        end else if (w_hs) begin
          wstate_next = W_DATA_OK;
        end
      end
      W_ADDR_OK: begin
        s_axi_lite_wready = 1'b1;
        w_hs = s_axi_lite_wvalid;
        if (w_hs) begin
          commit      = 1'b1;
          wstate_next = W_RESP;
        end
      end
      W_DATA_OK: begin
        s_axi_lite_awready = 1'b1;
        aw_hs = s_axi_lite_awvalid;
        if (aw_hs) begin
          commit      = 1'b1;
          wstate_next = W_RESP;
        end
      end
      W_RESP: begin
        s_axi_lite_bvalid = 1'b1;
        if (s_axi_lite_bready) wstate_next = W_IDLE;
      end
      default: wstate_next = W_IDLE;
    endcase
  end

  // The completing beat is taken straight from the bus, so registers update
  // on the same edge that enters W_RESP and are visible alongside bvalid.
  assign wr_addr = aw_hs ? s_axi_lite_awaddr : awaddr_q;
  assign wbit_rs = w_hs ? s_axi_lite_wdata[DMACR_RS_BIT] : wrs_q;
  assign wbit_12 = w_hs ? s_axi_lite_wdata[DMACR_IOC_IRQEN_BIT] : w12_q;
  assign wr_sel  = decode_addr(wr_addr);

  assign mm2s_cr_we = commit & (wr_sel == SEL_MM2S_CR);
  assign mm2s_sr_we = commit & (wr_sel == SEL_MM2S_SR);
  assign s2mm_cr_we = commit & (wr_sel == SEL_S2MM_CR);
  assign s2mm_sr_we = commit & (wr_sel == SEL_S2MM_SR);

  always_ff @(posedge clk) begin
    if (!rst) begin
      wstate           <= W_IDLE;
      awaddr_q         <= '0;
      wrs_q            <= 1'b0;
      w12_q            <= 1'b0;
      s_axi_lite_bresp <= RESP_OKAY;
    end else begin
      wstate <= wstate_next;
      if (aw_hs) awaddr_q <= s_axi_lite_awaddr;
      if (w_hs) begin
        wrs_q <= s_axi_lite_wdata[DMACR_RS_BIT];
        w12_q <= s_axi_lite_wdata[DMACR_IOC_IRQEN_BIT];
      end
      if (commit) s_axi_lite_bresp <= (wr_sel == SEL_NONE) ? RESP_SLVERR : RESP_OKAY;
    end
  end

endmodule
